fpu_fp32_add_issue: RTL and testbench
=====================================

Name: fpu_fp32_add_issue

Overview:
Pipelined issue/retire shell around the combinational FP32 add/sub core (fpu_fp32_add_core, instantiated externally). It accepts operations over a valid/ready handshake and registers the operands that drive the core. It captures the core result one stage later, overrides it for special operands the core does not handle (zero, Inf, NaN, denormal), and raises per-op and sticky exception flags. It sits between the FPU decode/regfile-read stage and FPU writeback.

Parameters:
TAGW, 5, width of the opaque destination tag carried alongside each op
QNAN, 32'h7FC0_0000, canonical NaN returned on invalid ops

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all in-flight ops
in_valid  in  1  op offered
in_ready  out  1  op accepted when in_valid&&in_ready
in_sub  in  1  1=srca-srcb, 0=srca+srcb
in_srca  in  32  operand A, IEEE single
in_srcb  in  32  operand B, IEEE single
in_tag  in  TAGW  destination tag
add_doSub  out  1  to core
add_srca  out  32  to core
add_srcb  out  32  to core
add_dst  in  32  from core (combinational on add_*)
out_valid  out  1  result available
out_ready  in  1  consumer accepts
out_result  out  32  final result
out_tag  out  TAGW  tag of result
out_flags  out  4  {V invalid, O overflow, U underflow-to-zero, D denormal input}
clr_flags  in  1  clear sticky flags
sticky_flags  out  4  OR of out_flags of every retired op

Behaviour:
- Reset (async, reset_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_tag=0, out_flags=0, sticky_flags=0, add_*=0; in_ready=1 once reset_n=1.
- Two stages. S1 registers operands plus classification bits (zero/denorm/inf/nan per operand, effective-sign). S2 registers the final result. Latency 2 cycles accept->out_valid. Throughput 1 op/cycle with no backpressure.
- s2_adv = !s2_valid || out_ready; s1_adv = s1_valid && s2_adv; in_ready = !s1_valid || s2_adv (combinational, no skid buffer).
- out_valid holds with stable result/tag/flags while out_ready=0.
- add_doSub/add_srca/add_srcb are driven straight from S1 registers. Denormals are flushed to signed zero in S1 (D set).
- S2 result select, priority order, with effective B sign = srcb[31]^sub:
  1. either NaN -> QNAN, V.
  2. Inf and Inf, opposite effective signs -> QNAN, V.
  3. any Inf -> that Inf with its effective sign.
  4. both zero -> sign = sa&sb_eff, magnitude 0.
  5. A zero -> B with effective sign; B zero -> A.
  6. otherwise add_dst.
     - add_dst exponent==FF -> O.
     - add_dst==0 with magnitudes unequal or effective signs equal -> U.
     - exact cancellation -> +0, no U.
- Sticky: on each retire (out_valid&&out_ready), sticky |= out_flags. clr_flags has priority over a same-cycle retire OR (sticky=0 that cycle).
- flush: next edge s1_valid=0, s2_valid=0. A same-cycle input is not accepted (in_ready forced 0 during flush); sticky unaffected.
- Reset mid-operation drops all ops, no partial outputs.

Decomposition:
- fpu_pkg: FP32 field constants (EXP_MSB=30, EXP_LSB=23, FRAC_W=23, EXP_ALL1=8'hFF), flag bit indices, QNAN value.
- One sub-module fpu_fp32_classify (combinational: zero/denorm/inf/nan/sign per operand), instantiated twice in S1.

Test Plan:
- 3F800000+40000000, out_ready=1 -> result 40400000 two cycles after accept, flags 0, back-to-back ops every cycle.
- 7F800000-7F800000 -> 7FC00000, V=1; 7FC00001+3F800000 -> 7FC00000, V=1; sticky_flags[V]=1 until clr_flags.
- 00000000+BF800000 -> BF800000; 80000000+80000000 -> 80000000; 3F800000-3F800000 -> 00000000, U=0.
- 7F7FFFFF+7F7FFFFF -> 7F800000, O=1; 00400000+3F800000 -> 3F800000, D=1.
- Hold out_ready=0 for 5 cycles with 4 ops offered -> exactly 2 accepted, in_ready=0, out_* stable; release -> results in order with correct tags.
- flush with S1 and S2 full -> out_valid=0 next cycle, no retire; reset_n pulse mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FP32 field constants, exception flag indices and the S1
// classification payload for the FP32 add/sub issue shell.
package fpu_pkg;

    localparam int unsigned FP_W     = 32;
    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned FRAC_W   = 23;
    localparam int unsigned FLAG_W   = 4;

    localparam logic [7:0] EXP_ALL1 = 8'hFF;
    localparam logic [7:0] EXP_ZERO = 8'h00;

    // out_flags bit positions: {V, O, U, D}
    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_O = 2;
    localparam int unsigned FLAG_U = 1;
    localparam int unsigned FLAG_D = 0;

    localparam logic [FP_W-1:0] QNAN_DEF = 32'h7FC0_0000;

    // Per-operand classification of a raw IEEE single.
    typedef struct packed {
        logic sign;
        logic zero;
        logic denorm;
        logic inf;
        logic nan;
    } fp_class_t;

    // Classification registered in S1 alongside the operands.
    // Zero bits already include flushed denormals; sb_eff folds in the op.
    typedef struct packed {
        logic a_zero;
        logic a_inf;
        logic a_nan;
        logic b_zero;
        logic b_inf;
        logic b_nan;
        logic sa;
        logic sb_eff;
        logic den;
    } s1_cls_t;

endpackage

// File: rtl/fpu_fp32_classify.sv
// Combinational IEEE single classifier.
// Ports: op    - raw operand
//        cls_c - sign / zero / denormal / infinity / NaN decode
module fpu_fp32_classify
    import fpu_pkg::*;
(
    input  logic [FP_W-1:0] op,
    output fp_class_t       cls_c
);

    logic exp_zero;
    logic exp_ones;
    logic frac_zero;

    assign exp_zero  = (op[EXP_MSB:EXP_LSB] == EXP_ZERO);
    assign exp_ones  = (op[EXP_MSB:EXP_LSB] == EXP_ALL1);
    assign frac_zero = (op[FRAC_W-1:0] == FRAC_W'(0));

    always_comb begin
        cls_c        = '0;
        cls_c.sign   = op[SIGN_BIT];
        cls_c.zero   = exp_zero && frac_zero;
        cls_c.denorm = exp_zero && !frac_zero;
        cls_c.inf    = exp_ones && frac_zero;
        cls_c.nan    = exp_ones && !frac_zero;
    end

endmodule

// File: rtl/fpu_fp32_add_issue.sv
// Two-stage issue/retire shell around an external combinational FP32 add/sub
// core. S1 registers flushed operands (driving the core) plus classification;
// S2 registers the final result with special-operand overrides and flags.
// Ports: clk/reset_n     - clock, async active-low reset
//        flush           - synchronous kill of all in-flight ops
//        in_*            - op offer (valid/ready), operands, op select, tag
//        add_doSub/srca/srcb, add_dst - interface to the external core
//        out_*           - result offer (valid/ready), result, tag, {V,O,U,D}
//        clr_flags, sticky_flags - sticky exception accumulator
module fpu_fp32_add_issue
    import fpu_pkg::*;
#(
    parameter int unsigned      TAGW = 5,
    parameter logic [FP_W-1:0]  QNAN = QNAN_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sub,
    input  logic [FP_W-1:0]   in_srca,
    input  logic [FP_W-1:0]   in_srcb,
    input  logic [TAGW-1:0]   in_tag,
    output logic              add_doSub,
    output logic [FP_W-1:0]   add_srca,
    output logic [FP_W-1:0]   add_srcb,
    input  logic [FP_W-1:0]   add_dst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP_W-1:0]   out_result,
    output logic [TAGW-1:0]   out_tag,
    output logic [FLAG_W-1:0] out_flags,
    input  logic              clr_flags,
    output logic [FLAG_W-1:0] sticky_flags
);

    fp_class_t         cls_a_c;
    fp_class_t         cls_b_c;
    logic [FP_W-1:0]   srca_ftz_c;
    logic [FP_W-1:0]   srcb_ftz_c;
    logic              s2_adv_c;
    logic              s1_adv_c;
    logic              accept_c;
    logic              mag_eq_c;
    logic [FP_W-1:0]   res_c;
    logic [FLAG_W-1:0] flags_c;

    logic              s1_valid;
    logic [TAGW-1:0]   s1_tag;
    s1_cls_t           s1_cls;

    fpu_fp32_classify u_cls_a (.op(in_srca), .cls_c(cls_a_c));
    fpu_fp32_classify u_cls_b (.op(in_srcb), .cls_c(cls_b_c));

    // Pipeline handshake; out_valid is the S2 valid bit.
    assign s2_adv_c = !out_valid || out_ready;
    assign s1_adv_c = s1_valid && s2_adv_c;
    assign in_ready = !flush && (!s1_valid || s2_adv_c);
    assign accept_c = in_valid && in_ready;

    // Denormals become signed zero before they reach the core.
    assign srca_ftz_c = cls_a_c.denorm ? {in_srca[SIGN_BIT], (FP_W-1)'(0)} : in_srca;
    assign srcb_ftz_c = cls_b_c.denorm ? {in_srcb[SIGN_BIT], (FP_W-1)'(0)} : in_srcb;

    // S1: operand and classification registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_tag    <= '0;
            s1_cls    <= '0;
            add_doSub <= 1'b0;
            add_srca  <= '0;
            add_srcb  <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (accept_c) begin
                s1_valid <= 1'b1;
            end else if (s1_adv_c) begin
                s1_valid <= 1'b0;
            end
            if (accept_c) begin
                add_doSub     <= in_sub;
                add_srca      <= srca_ftz_c;
                add_srcb      <= srcb_ftz_c;
                s1_tag        <= in_tag;
                s1_cls.a_zero <= cls_a_c.zero || cls_a_c.denorm;
                s1_cls.a_inf  <= cls_a_c.inf;
                s1_cls.a_nan  <= cls_a_c.nan;
                s1_cls.b_zero <= cls_b_c.zero || cls_b_c.denorm;
                s1_cls.b_inf  <= cls_b_c.inf;
                s1_cls.b_nan  <= cls_b_c.nan;
                s1_cls.sa     <= cls_a_c.sign;
                s1_cls.sb_eff <= cls_b_c.sign ^ in_sub;
                s1_cls.den    <= cls_a_c.denorm || cls_b_c.denorm;
            end
        end
    end

    assign mag_eq_c = (add_srca[EXP_MSB:0] == add_srcb[EXP_MSB:0]);

    // Result select: special operands override the core, in priority order.
    always_comb begin
        res_c          = add_dst;
        flags_c        = '0;
        flags_c[FLAG_D] = s1_cls.den;
        if (s1_cls.a_nan || s1_cls.b_nan) begin
            res_c           = QNAN;
            flags_c[FLAG_V] = 1'b1;
        end else if (s1_cls.a_inf && s1_cls.b_inf && (s1_cls.sa != s1_cls.sb_eff)) begin
            res_c           = QNAN;
            flags_c[FLAG_V] = 1'b1;
        end else if (s1_cls.a_inf) begin
            res_c = {s1_cls.sa, EXP_ALL1, FRAC_W'(0)};
        end else if (s1_cls.b_inf) begin
            res_c = {s1_cls.sb_eff, EXP_ALL1, FRAC_W'(0)};
        end else if (s1_cls.a_zero && s1_cls.b_zero) begin
            res_c = {s1_cls.sa & s1_cls.sb_eff, (FP_W-1)'(0)};
        end else if (s1_cls.a_zero) begin
            res_c = {s1_cls.sb_eff, add_srcb[EXP_MSB:0]};
        end else if (s1_cls.b_zero) begin
            res_c = add_srca;
        end else begin
            if (add_dst[EXP_MSB:EXP_LSB] == EXP_ALL1) begin
                flags_c[FLAG_O] = 1'b1;
            end
            // A zero core result is either exact cancellation (+0) or underflow.
            if (add_dst[EXP_MSB:0] == (FP_W-1)'(0)) begin
                if (mag_eq_c && (s1_cls.sa != s1_cls.sb_eff)) begin
                    res_c = '0;
                end else begin
                    flags_c[FLAG_U] = 1'b1;
                end
            end
        end
    end

    // S2: result registers, held while the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_flags  <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (s2_adv_c) begin
                out_valid <= s1_valid;
            end
            if (s1_adv_c) begin
                out_result <= res_c;
                out_tag    <= s1_tag;
                out_flags  <= flags_c;
            end
        end
    end

    // Sticky flags accumulate on retire; a clear wins over a same-cycle retire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_flags <= '0;
        end else if (clr_flags) begin
            sticky_flags <= '0;
        end else if (out_valid && out_ready) begin
            sticky_flags <= sticky_flags | out_flags;
        end
    end

endmodule

// File: tb/tb_fpu_fp32_add_issue.sv
// Directed scoreboard bench for fpu_fp32_add_issue. The external add core is
// modelled by a lookup of the exact sums used by the stimulus.
module tb_fpu_fp32_add_issue;

    localparam int unsigned TAGW = 5;
    localparam logic [31:0] QN   = 32'h7FC0_0000;

    logic            clk;
    logic            reset_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            in_sub;
    logic [31:0]     in_srca;
    logic [31:0]     in_srcb;
    logic [TAGW-1:0] in_tag;
    logic            add_doSub;
    logic [31:0]     add_srca;
    logic [31:0]     add_srcb;
    logic [31:0]     add_dst;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_result;
    logic [TAGW-1:0] out_tag;
    logic [3:0]      out_flags;
    logic            clr_flags;
    logic [3:0]      sticky_flags;

    fpu_fp32_add_issue #(.TAGW(TAGW), .QNAN(QN)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
        .in_srca(in_srca), .in_srcb(in_srcb), .in_tag(in_tag),
        .add_doSub(add_doSub), .add_srca(add_srca), .add_srcb(add_srcb),
        .add_dst(add_dst),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_flags(out_flags),
        .clr_flags(clr_flags), .sticky_flags(sticky_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     result;
        logic [TAGW-1:0] tag;
        logic [3:0]      flags;
    } exp_t;

    exp_t            scb[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    logic [TAGW-1:0] tag_ctr = '0;
    logic [3:0]      exp_sticky = '0;

    // Core stand-in: exact, round-to-nearest, flush-to-zero results.
    function automatic logic [31:0] core_model(logic sub, logic [31:0] a, logic [31:0] b);
        case ({sub, a, b})
            {1'b0, 32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
            {1'b0, 32'h4000_0000, 32'h4040_0000}: return 32'h40A0_0000;
            {1'b0, 32'h4040_0000, 32'h4080_0000}: return 32'h40E0_0000;
            {1'b1, 32'h4080_0000, 32'h3F80_0000}: return 32'h4040_0000;
            {1'b0, 32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
            {1'b1, 32'h3F80_0000, 32'h3F80_0000}: return 32'h0000_0000;
            {1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF}: return 32'h7F80_0000;
            {1'b0, 32'h0080_0001, 32'h8080_0000}: return 32'h0000_0000;
            default:                              return 32'h0BAD_0BAD;
        endcase
    endfunction

    always_comb add_dst = core_model(add_doSub, add_srca, add_srcb);

    // Reference: {result, V, O, U, D} for one operation.
    function automatic logic [35:0] ref_op(logic sub, logic [31:0] a, logic [31:0] b);
        logic [31:0] fa;
        logic [31:0] fb;
        logic [31:0] r;
        logic        d, v, o, u, sa, sbe, an, bn, ai, bi, az, bz;
        fa = a; fb = b; d = 1'b0; v = 1'b0; o = 1'b0; u = 1'b0;
        if (a[30:23] == 8'h00 && a[22:0] != 23'd0) begin fa = {a[31], 31'd0}; d = 1'b1; end
        if (b[30:23] == 8'h00 && b[22:0] != 23'd0) begin fb = {b[31], 31'd0}; d = 1'b1; end
        sa  = fa[31];
        sbe = fb[31] ^ sub;
        an  = (fa[30:23] == 8'hFF) && (fa[22:0] != 23'd0);
        bn  = (fb[30:23] == 8'hFF) && (fb[22:0] != 23'd0);
        ai  = (fa[30:23] == 8'hFF) && (fa[22:0] == 23'd0);
        bi  = (fb[30:23] == 8'hFF) && (fb[22:0] == 23'd0);
        az  = (fa[30:0] == 31'd0);
        bz  = (fb[30:0] == 31'd0);
        if (an || bn) begin
            r = QN; v = 1'b1;
        end else if (ai && bi && (sa != sbe)) begin
            r = QN; v = 1'b1;
        end else if (ai) begin
            r = fa;
        end else if (bi) begin
            r = {sbe, fb[30:0]};
        end else if (az && bz) begin
            r = {sa & sbe, 31'd0};
        end else if (az) begin
            r = {sbe, fb[30:0]};
        end else if (bz) begin
            r = fa;
        end else begin
            r = core_model(sub, fa, fb);
            if (r[30:23] == 8'hFF) o = 1'b1;
            if (r[30:0] == 31'd0) begin
                if ((fa[30:0] == fb[30:0]) && (sa != sbe)) r = 32'd0;
                else u = 1'b1;
            end
        end
        return {r, v, o, u, d};
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // One clock: drive inputs, check/pop a retiring result, push an accepted op.
    task automatic step(input logic v, input logic sub, input logic [31:0] a,
                        input logic [31:0] b, input logic ordy, input logic fl,
                        input logic clr, output logic fired);
        exp_t        e;
        logic [35:0] rr;
        logic        popped;
        in_valid = v; in_sub = sub; in_srca = a; in_srcb = b; in_tag = tag_ctr;
        out_ready = ordy; flush = fl; clr_flags = clr;
        popped = 1'b0;
        e = '0;
        #1;
        check("sticky", 32'(sticky_flags), 32'(exp_sticky));
        fired = v && in_ready;
        if (out_valid && ordy) begin
            n_cmp++;
            assert (scb.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_output: observed result %h tag %0d, expected none",
                       out_result, out_tag);
            end
            if (scb.size() != 0) begin
                e = scb.pop_front();
                popped = 1'b1;
                check("result", out_result, e.result);
                check("tag", 32'(out_tag), 32'(e.tag));
                check("flags", 32'(out_flags), 32'(e.flags));
            end
        end
        if (clr) exp_sticky = '0;
        else if (popped) exp_sticky = exp_sticky | e.flags;
        if (fired) begin
            rr = ref_op(sub, a, b);
            scb.push_back({rr[35:4], tag_ctr, rr[3:0]});
            tag_ctr = tag_ctr + 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy, input logic clr);
        logic f;
        step(1'b0, 1'b0, 32'd0, 32'd0, ordy, 1'b0, clr, f);
    endtask

    task automatic issue(input logic sub, input logic [31:0] a, input logic [31:0] b);
        logic f;
        step(1'b1, sub, a, b, 1'b1, 1'b0, 1'b0, f);
        check("accept", 32'(f), 32'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (scb.size() != 0 && k < 20) begin
            idle(1'b1, 1'b0);
            k++;
        end
        check("drain_empty", 32'(scb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        f;
        int          idx;
        int          k;
        logic        ssub[4];
        logic [31:0] sa_arr[4];
        logic [31:0] sb_arr[4];

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sub = 1'b0;
        in_srca = '0; in_srcb = '0; in_tag = '0; out_ready = 1'b0; clr_flags = 1'b0;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_sticky", 32'(sticky_flags), 32'd0);
        check("rst_add_srca", add_srca, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Latency: visible two edges after the offer cycle.
        issue(1'b0, 32'h3F80_0000, 32'h4000_0000);
        check("lat_s1_only", 32'(out_valid), 32'd0);
        idle(1'b1, 1'b0);
        check("lat_s2", 32'(out_valid), 32'd1);

        // Back-to-back, one op per cycle.
        issue(1'b0, 32'h4000_0000, 32'h4040_0000);
        issue(1'b0, 32'h4040_0000, 32'h4080_0000);
        issue(1'b1, 32'h4080_0000, 32'h3F80_0000);
        issue(1'b0, 32'h3F80_0000, 32'h3F80_0000);
        drain();

        // Invalid and infinity operands.
        issue(1'b1, 32'h7F80_0000, 32'h7F80_0000);
        issue(1'b0, 32'h7FC0_0001, 32'h3F80_0000);
        issue(1'b0, 32'h7F80_0000, 32'h3F80_0000);
        issue(1'b1, 32'h3F80_0000, 32'h7F80_0000);
        drain();
        check("sticky_v_set", 32'(sticky_flags[3]), 32'd1);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        check("sticky_cleared", 32'(sticky_flags), 32'd0);

        // Zeros, cancellation, overflow, denormal input, underflow.
        issue(1'b0, 32'h0000_0000, 32'hBF80_0000);
        issue(1'b0, 32'h8000_0000, 32'h8000_0000);
        issue(1'b1, 32'h3F80_0000, 32'h3F80_0000);
        issue(1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF);
        issue(1'b0, 32'h0040_0000, 32'h3F80_0000);
        issue(1'b0, 32'h0080_0001, 32'h8080_0000);
        drain();

        // Clear has priority over a same-cycle retire.
        issue(1'b0, 32'h7FC0_0001, 32'h3F80_0000);
        idle(1'b0, 1'b0);
        check("clr_retire_pending", 32'(out_valid), 32'd1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);

        // Backpressure: 5 stalled cycles, 4 ops offered.
        ssub[0] = 1'b0; sa_arr[0] = 32'h3F80_0000; sb_arr[0] = 32'h4000_0000;
        ssub[1] = 1'b0; sa_arr[1] = 32'h7FC0_0001; sb_arr[1] = 32'h3F80_0000;
        ssub[2] = 1'b0; sa_arr[2] = 32'h4000_0000; sb_arr[2] = 32'h4040_0000;
        ssub[3] = 1'b0; sa_arr[3] = 32'h4040_0000; sb_arr[3] = 32'h4080_0000;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 4) step(1'b1, ssub[idx], sa_arr[idx], sb_arr[idx], 1'b0, 1'b0, 1'b0, f);
            else step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, f);
            if (f) idx++;
            if (c >= 2 && scb.size() != 0) begin
                check("stall_result", out_result, scb[0].result);
                check("stall_tag", 32'(out_tag), 32'(scb[0].tag));
            end
        end
        check("stall_accepted", 32'(idx), 32'd2);
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        k = 0;
        while (idx < 4 && k < 20) begin
            step(1'b1, ssub[idx], sa_arr[idx], sb_arr[idx], 1'b1, 1'b0, 1'b0, f);
            if (f) idx++;
            k++;
        end
        check("release_accepted", 32'(idx), 32'd4);
        drain();

        // Flush with both stages full.
        step(1'b1, 1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, f);
        step(1'b1, 1'b0, 32'h7FC0_0001, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, f);
        step(1'b1, 1'b0, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b1, 1'b0, f);
        check("flush_no_accept", 32'(f), 32'd0);
        scb.delete();
        check("flush_out_valid", 32'(out_valid), 32'd0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("flush_s1_empty", 32'(out_valid), 32'd0);
        issue(1'b0, 32'h4040_0000, 32'h4080_0000);
        drain();

        // Asynchronous reset mid-stream.
        step(1'b1, 1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, f);
        step(1'b1, 1'b1, 32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b0, 1'b0, f);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_result", out_result, 32'd0);
        check("arst_out_tag", 32'(out_tag), 32'd0);
        check("arst_out_flags", 32'(out_flags), 32'd0);
        check("arst_sticky", 32'(sticky_flags), 32'd0);
        check("arst_add_srca", add_srca, 32'd0);
        check("arst_add_dosub", 32'(add_doSub), 32'd0);
        scb.delete();
        exp_sticky = '0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(1'b1, 1'b0);
        check("arst_no_output", 32'(out_valid), 32'd0);
        issue(1'b0, 32'h3F80_0000, 32'h3F80_0000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
